braille_to_bcd_rx: RTL

- Receive-side counterpart of the BCD-to-Braille digit converter: accepts a stream of 4-dot Braille digit cells (w,x,y,z) over a valid/ready handshake.
- Validates and decodes each cell to BCD, then packs a multi-digit number of up to NUM_DIGITS digits.
- A blank cell terminates the number; the packed result is presented on a held output handshake.
- Sits between a Braille cell source (keypad/sensor front end) and BCD consumers (display, arithmetic).

---
 rtl/braille_to_bcd_rx.sv | 126 ++++++++++++
 1 files changed

// File: rtl/braille_to_bcd_rx.sv
// Braille digit-cell receiver: decodes 4-dot cells {w,x,y,z} to BCD and packs
// a number of up to NUM_DIGITS digits, terminated by a blank cell.
module braille_to_bcd_rx #(
    parameter int NUM_DIGITS = 4,
    parameter int CNT_W      = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    w,
    input  logic                    x,
    input  logic                    y,
    input  logic                    z,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [4*NUM_DIGITS-1:0] bcd_out,
    output logic [CNT_W-1:0]        digit_count,
    output logic                    error
);
    typedef enum logic [1:0] {IDLE, ACCUM, ERR_DRAIN, HOLD} state_t;

    state_t                  r_state;
    logic [4*NUM_DIGITS-1:0] r_acc;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_in_ready;
    logic                    r_out_valid;
    logic [4*NUM_DIGITS-1:0] r_bcd_out;
    logic [CNT_W-1:0]        r_digit_count;
    logic                    r_error;

    logic       w_blank;
    logic       w_invalid;
    logic [3:0] w_digit;
    logic       w_accept;
    logic       w_full;

    always_comb begin
        w_blank   = 1'b0;
        w_invalid = 1'b0;
        w_digit   = 4'd0;
        case ({w, x, y, z})
            4'b1000: w_digit = 4'd1;
            4'b1010: w_digit = 4'd2;
            4'b1100: w_digit = 4'd3;
            4'b1101: w_digit = 4'd4;
            4'b1001: w_digit = 4'd5;
            4'b1110: w_digit = 4'd6;
            4'b1111: w_digit = 4'd7;
            4'b1011: w_digit = 4'd8;
            4'b0110: w_digit = 4'd9;
            4'b0111: w_digit = 4'd0;
            4'b0000: w_blank = 1'b1;
            default: w_invalid = 1'b1;
        endcase
    end

    assign w_accept = in_valid && r_in_ready;
    assign w_full   = (r_cnt == CNT_W'(NUM_DIGITS));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_acc         <= '0;
            r_cnt         <= '0;
            r_in_ready    <= 1'b1;
            r_out_valid   <= 1'b0;
            r_bcd_out     <= '0;
            r_digit_count <= '0;
            r_error       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (w_accept) begin
                    if (w_invalid) begin
                        r_state <= ERR_DRAIN;
                    end else if (!w_blank) begin
                        r_acc   <= {r_acc[4*NUM_DIGITS-5:0], w_digit};
                        r_cnt   <= CNT_W'(1);
                        r_state <= ACCUM;
                    end
                end
                ACCUM: if (w_accept) begin
                    if (w_blank) begin
                        r_state       <= HOLD;
                        r_bcd_out     <= r_acc;
                        r_digit_count <= r_cnt;
                        r_error       <= 1'b0;
                        r_out_valid   <= 1'b1;
                        r_in_ready    <= 1'b0;
                    end else if (w_invalid || w_full) begin
                        r_state <= ERR_DRAIN;
                    end else begin
                        r_acc <= {r_acc[4*NUM_DIGITS-5:0], w_digit};
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ERR_DRAIN: if (w_accept && w_blank) begin
                    // Error report carries no partial digits.
                    r_state       <= HOLD;
                    r_bcd_out     <= '0;
                    r_digit_count <= '0;
                    r_error       <= 1'b1;
                    r_out_valid   <= 1'b1;
                    r_in_ready    <= 1'b0;
                end
                HOLD: if (r_out_valid && out_ready) begin
                    r_state       <= IDLE;
                    r_acc         <= '0;
                    r_cnt         <= '0;
                    r_bcd_out     <= '0;
                    r_digit_count <= '0;
                    r_error       <= 1'b0;
                    r_out_valid   <= 1'b0;
                    r_in_ready    <= 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign bcd_out     = r_bcd_out;
    assign digit_count = r_digit_count;
    assign error       = r_error;
endmodule
